garegga_pcm_fetch: RTL and testbench

- Read-only PCM sample fetch stage sitting directly downstream of the Garegga sound block's PCM ROM port.
- Accepts byte addresses and chip-select from the sound block's jt6295 (via the NMK112 banking path) and returns bytes with a ready flag.
- Fetches 16-bit words from the SDRAM ROM slot through a req/ok handshake.
- A small direct-mapped word cache hides SDRAM latency for the sequential ADPCM nibble reads.

---
 rtl/garegga_pcm_fetch_if.sv | 14 +
 rtl/garegga_pcm_fetch.sv | 165 ++++++++++++++++
 tb/tb_garegga_pcm_fetch.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/garegga_pcm_fetch_if.sv
// Read-only byte/word bus: the requester drives cs/addr, the responder returns data/ok.
// Used for both the PCM client side (DW=8) and the SDRAM ROM slot (DW=16).
interface garegga_pcm_fetch_if #(
    parameter int unsigned AW = 20,
    parameter int unsigned DW = 8
);
    logic          cs;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          ok;

    modport master (output cs, output addr, input data, input ok);
    modport slave  (input cs, input addr, output data, output ok);
endinterface

// File: rtl/garegga_pcm_fetch.sv
// Garegga PCM ROM fetch stage: direct-mapped one-word-per-line cache in front of the SDRAM slot.
// Optional next-word prefetch after each demand fill: define PCM_FETCH_PREFETCH_EN.
module garegga_pcm_fetch #(
    parameter int unsigned AW    = 20,
    parameter int unsigned LINES = 8
) (
    input  logic                CLK96,
    input  logic                RESET96,
    input  logic                INVALIDATE,
    garegga_pcm_fetch_if.slave  pcm,
    garegga_pcm_fetch_if.master sdram
);
    localparam int unsigned WW = AW - 1;
    localparam int unsigned IW = $clog2(LINES);
    localparam int unsigned TW = WW - IW;

    typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             cs_q, cs_d;
    logic             pcm_ok_q, pcm_ok_d;
    logic [7:0]       pcm_dout_q, pcm_dout_d;
    logic             sdram_cs_q, sdram_cs_d;
    logic [WW-1:0]    sdram_addr_q, sdram_addr_d;
    logic             kill_q, kill_d;
    logic [LINES-1:0] valid_q, valid_d;
    logic [TW-1:0]    tag_q  [LINES];
    logic [TW-1:0]    tag_d  [LINES];
    logic [15:0]      data_q [LINES];
    logic [15:0]      data_d [LINES];

    logic [WW-1:0] word;
    logic [IW-1:0] idx;
    logic [TW-1:0] tag;
    logic [15:0]   line;
    logic [IW-1:0] fill_idx;
    logic [TW-1:0] fill_tag;
    logic          hit;
    logic          stable;

`ifdef PCM_FETCH_PREFETCH_EN
    logic          pf_q, pf_d;
    logic [WW-1:0] next_word;
    logic [IW-1:0] next_idx;
    logic          next_present;

    assign next_word    = sdram_addr_q + WW'(1);
    assign next_idx     = next_word[IW-1:0];
    assign next_present = valid_q[next_idx] && (tag_q[next_idx] == next_word[WW-1:IW]);
`endif

    assign word     = addr_q[AW-1:1];
    assign idx      = word[IW-1:0];
    assign tag      = word[WW-1:IW];
    assign line     = data_q[idx];
    assign fill_idx = sdram_addr_q[IW-1:0];
    assign fill_tag = sdram_addr_q[WW-1:IW];
    assign hit      = cs_q & valid_q[idx] & (tag_q[idx] == tag);
    // Stable means the client is still presenting the address captured last edge.
    assign stable   = pcm.cs & cs_q & (pcm.addr == addr_q);

    always_comb begin
        state_d      = state_q;
        addr_d       = pcm.addr;
        cs_d         = pcm.cs;
        pcm_ok_d     = 1'b0;
        pcm_dout_d   = pcm_dout_q;
        sdram_cs_d   = sdram_cs_q;
        sdram_addr_d = sdram_addr_q;
        kill_d       = kill_q;
        valid_d      = valid_q;
        tag_d        = tag_q;
        data_d       = data_q;
`ifdef PCM_FETCH_PREFETCH_EN
        pf_d         = pf_q;
`endif

        if (stable && hit && !INVALIDATE) begin
            pcm_ok_d   = 1'b1;
            pcm_dout_d = addr_q[0] ? line[15:8] : line[7:0];
        end

        if (INVALIDATE) valid_d = '0;

        case (state_q)
            IDLE: begin
                if (stable && !hit) begin
                    sdram_addr_d = word;
                    sdram_cs_d   = 1'b1;
                    state_d      = REQ;
                end
            end
            REQ: begin
                if (INVALIDATE) kill_d = 1'b1;
                if (sdram.ok) begin
                    data_d[fill_idx]  = sdram.data;
                    tag_d[fill_idx]   = fill_tag;
                    // A same-edge invalidate already zeroed valid_d; keep this line dead too.
                    valid_d[fill_idx] = !(kill_q || INVALIDATE);
                    sdram_cs_d        = 1'b0;
                    kill_d            = 1'b0;
                    state_d           = FILL;
                end
            end
            FILL: begin
`ifdef PCM_FETCH_PREFETCH_EN
                if (!pf_q && !next_present) begin
                    sdram_addr_d = next_word;
                    sdram_cs_d   = 1'b1;
                    pf_d         = 1'b1;
                    state_d      = REQ;
                end else begin
                    pf_d    = 1'b0;
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK96 or posedge RESET96) begin
        if (RESET96) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            cs_q         <= 1'b0;
            pcm_ok_q     <= 1'b0;
            pcm_dout_q   <= '0;
            sdram_cs_q   <= 1'b0;
            sdram_addr_q <= '0;
            kill_q       <= 1'b0;
            valid_q      <= '0;
            for (int unsigned i = 0; i < LINES; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
`ifdef PCM_FETCH_PREFETCH_EN
            pf_q         <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cs_q         <= cs_d;
            pcm_ok_q     <= pcm_ok_d;
            pcm_dout_q   <= pcm_dout_d;
            sdram_cs_q   <= sdram_cs_d;
            sdram_addr_q <= sdram_addr_d;
            kill_q       <= kill_d;
            valid_q      <= valid_d;
            tag_q        <= tag_d;
            data_q       <= data_d;
`ifdef PCM_FETCH_PREFETCH_EN
            pf_q         <= pf_d;
`endif
        end
    end

    assign pcm.data   = pcm_dout_q;
    assign pcm.ok     = pcm_ok_q;
    assign sdram.cs   = sdram_cs_q;
    assign sdram.addr = sdram_addr_q;
endmodule

// File: tb/tb_garegga_pcm_fetch.sv
// Directed bench for garegga_pcm_fetch with a fixed-latency SDRAM responder model.
module tb_garegga_pcm_fetch;
    localparam int unsigned AW = 20;

    logic CLK96      = 1'b0;
    logic RESET96    = 1'b1;
    logic INVALIDATE = 1'b0;

    always #5 CLK96 = ~CLK96;

    garegga_pcm_fetch_if #(.AW(AW),     .DW(8))  pcm_bus ();
    garegga_pcm_fetch_if #(.AW(AW - 1), .DW(16)) sd_bus ();

    garegga_pcm_fetch #(.AW(AW), .LINES(8)) dut (
        .CLK96      (CLK96),
        .RESET96    (RESET96),
        .INVALIDATE (INVALIDATE),
        .pcm        (pcm_bus),
        .sdram      (sd_bus)
    );

    int          checks = 0;
    int          errors = 0;
    int          req_count = 0;
    logic [18:0] last_req_addr = '0;
    bit          hold_check_en = 1'b1;

    function automatic logic [15:0] rom(input logic [18:0] w);
        case (w)
            19'h00008: return 16'hBEEF;
            19'h00048: return 16'h1234;
            default:   return {w[7:0] ^ 8'hA5, w[7:0] ^ 8'h5A};
        endcase
    endfunction

    // SDRAM slot: answers each request 5 cycles after CS is seen, checks CS/ADDR are held.
    initial begin : sdram_model
        logic [18:0] a;
        sd_bus.ok   = 1'b0;
        sd_bus.data = '0;
        forever begin
            @(negedge CLK96);
            if (sd_bus.cs === 1'b1) begin
                a = sd_bus.addr;
                req_count++;
                last_req_addr = a;
                repeat (4) begin
                    @(negedge CLK96);
                    if (hold_check_en) begin
                        checks++;
                        if (sd_bus.cs !== 1'b1 || sd_bus.addr !== a) begin
                            errors++;
                            $display("FAIL sdram_hold cs=%b addr=%h required cs=1 addr=%h", sd_bus.cs, sd_bus.addr, a);
                        end
                    end
                end
                sd_bus.data = rom(a);
                sd_bus.ok   = 1'b1;
                @(negedge CLK96);
                sd_bus.ok   = 1'b0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not finish, required finish");
        $fatal(1);
    end

    task automatic tick();
        @(negedge CLK96);
        #1;
    endtask

    task automatic wait_ok(input int maxc, output bit got);
        int cyc = 0;
        got = 1'b0;
        while (!got && cyc < maxc) begin
            tick();
            cyc++;
            if (pcm_bus.ok === 1'b1) got = 1'b1;
        end
    endtask

    task automatic wait_sd_cs(output bit got);
        int cyc = 0;
        got = 1'b0;
        while (!got && cyc < 20) begin
            tick();
            cyc++;
            if (sd_bus.cs === 1'b1) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLK96);
        #1;
        checks++; if (pcm_bus.ok !== 1'b0) begin errors++; $display("FAIL rst_ok got %b required 0", pcm_bus.ok); end
        checks++; if (pcm_bus.data !== 8'h00) begin errors++; $display("FAIL rst_dout got %h required 00", pcm_bus.data); end
        checks++; if (sd_bus.cs !== 1'b0) begin errors++; $display("FAIL rst_sdcs got %b required 0", sd_bus.cs); end
        checks++; if (sd_bus.addr !== 19'h0) begin errors++; $display("FAIL rst_sdaddr got %h required 0", sd_bus.addr); end
        RESET96 = 1'b0;
        tick();
        checks++; if (pcm_bus.ok !== 1'b0) begin errors++; $display("FAIL rst_release_ok got %b required 0", pcm_bus.ok); end
    endtask

    task automatic test_basic();
        bit got;
        int rc0 = req_count;
        pcm_bus.cs   = 1'b1;
        pcm_bus.addr = 20'h00010;
        tick();
        tick();
        checks++; if (sd_bus.cs !== 1'b1) begin errors++; $display("FAIL miss_sdcs got %b required 1", sd_bus.cs); end
        checks++; if (sd_bus.addr !== 19'h00008) begin errors++; $display("FAIL miss_sdaddr got %h required 00008", sd_bus.addr); end
        wait_ok(30, got);
        checks++; if (!got) begin errors++; $display("FAIL fill_ok got timeout required ok=1"); end
        checks++; if (pcm_bus.data !== 8'hEF) begin errors++; $display("FAIL fill_dout got %h required ef", pcm_bus.data); end
        checks++; if (req_count - rc0 !== 1) begin errors++; $display("FAIL fill_reqs got %0d required 1", req_count - rc0); end
        pcm_bus.addr = 20'h00011;
        tick();
        checks++; if (pcm_bus.ok !== 1'b0) begin errors++; $display("FAIL hi_ok_drop got %b required 0", pcm_bus.ok); end
        tick();
        checks++; if (pcm_bus.ok !== 1'b1) begin errors++; $display("FAIL hi_ok got %b required 1", pcm_bus.ok); end
        checks++; if (pcm_bus.data !== 8'hBE) begin errors++; $display("FAIL hi_dout got %h required be", pcm_bus.data); end
        tick();
        checks++; if (pcm_bus.ok !== 1'b1) begin errors++; $display("FAIL hi_ok_hold got %b required 1", pcm_bus.ok); end
        checks++; if (req_count - rc0 !== 1) begin errors++; $display("FAIL hi_reqs got %0d required 1", req_count - rc0); end
        pcm_bus.cs = 1'b0;
        tick();
        checks++; if (pcm_bus.ok !== 1'b0) begin errors++; $display("FAIL cs_low_ok got %b required 0", pcm_bus.ok); end
        pcm_bus.addr = 20'h00070;
        repeat (10) tick();
        checks++; if (req_count - rc0 !== 1) begin errors++; $display("FAIL cs_low_reqs got %0d required 1", req_count - rc0); end
    endtask

    task automatic test_conflict();
        bit got;
        int rc0 = req_count;
        pcm_bus.cs   = 1'b1;
        pcm_bus.addr = 20'h00090;
        wait_ok(30, got);
        checks++; if (!got || pcm_bus.data !== 8'h34) begin errors++; $display("FAIL conflict_dout got ok=%b %h required ok=1 34", got, pcm_bus.data); end
        checks++; if (last_req_addr !== 19'h00048 || req_count - rc0 !== 1) begin errors++; $display("FAIL conflict_req got %h/%0d required 00048/1", last_req_addr, req_count - rc0); end
        pcm_bus.addr = 20'h00010;
        wait_ok(30, got);
        checks++; if (!got || pcm_bus.data !== 8'hEF) begin errors++; $display("FAIL refetch_dout got ok=%b %h required ok=1 ef", got, pcm_bus.data); end
        checks++; if (last_req_addr !== 19'h00008 || req_count - rc0 !== 2) begin errors++; $display("FAIL refetch_req got %h/%0d required 00008/2", last_req_addr, req_count - rc0); end
    endtask

    task automatic test_addr_change();
        bit got;
        int bad = 0;
        int cyc = 0;
        int rc0 = req_count;
        pcm_bus.addr = 20'h00020;
        wait_sd_cs(got);
        checks++; if (!got) begin errors++; $display("FAIL chg_first_req got timeout required sdram cs"); end
        pcm_bus.addr = 20'h00040;
        got = 1'b0;
        while (!got && cyc < 50) begin
            tick();
            cyc++;
            if (pcm_bus.ok === 1'b1) begin
                got = 1'b1;
                if (pcm_bus.data !== 8'h7A) bad++;
            end
        end
        checks++; if (!got || pcm_bus.data !== 8'h7A) begin errors++; $display("FAIL chg_dout got ok=%b %h required ok=1 7a", got, pcm_bus.data); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL chg_stale_ok got %0d required 0", bad); end
        checks++; if (last_req_addr !== 19'h00020 || req_count - rc0 !== 2) begin errors++; $display("FAIL chg_reqs got %h/%0d required 00020/2", last_req_addr, req_count - rc0); end
    endtask

    task automatic test_invalidate();
        bit got;
        int early = 0;
        int cyc = 0;
        int rc0 = req_count;
        pcm_bus.addr = 20'h00030;
        wait_sd_cs(got);
        INVALIDATE = 1'b1;
        tick();
        INVALIDATE = 1'b0;
        got = 1'b0;
        while (!got && cyc < 50) begin
            tick();
            cyc++;
            if (pcm_bus.ok === 1'b1) begin
                got = 1'b1;
                if (req_count - rc0 < 2) early++;
            end
        end
        checks++; if (!got || pcm_bus.data !== 8'h42) begin errors++; $display("FAIL inv_req_dout got ok=%b %h required ok=1 42", got, pcm_bus.data); end
        checks++; if (early !== 0) begin errors++; $display("FAIL inv_req_early_ok got %0d required 0", early); end
        checks++; if (last_req_addr !== 19'h00018 || req_count - rc0 !== 2) begin errors++; $display("FAIL inv_req_reqs got %h/%0d required 00018/2", last_req_addr, req_count - rc0); end
    endtask

    task automatic test_inv_on_ok();
        bit got;
        int early = 0;
        int cyc = 0;
        int rc0 = req_count;
        pcm_bus.addr = 20'h00050;
        while (sd_bus.ok !== 1'b1 && cyc < 30) begin
            tick();
            cyc++;
        end
        checks++; if (sd_bus.ok !== 1'b1) begin errors++; $display("FAIL inv_ok_resp got timeout required sdram ok"); end
        INVALIDATE = 1'b1;
        tick();
        INVALIDATE = 1'b0;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 50) begin
            tick();
            cyc++;
            if (pcm_bus.ok === 1'b1) begin
                got = 1'b1;
                if (req_count - rc0 < 2) early++;
            end
        end
        checks++; if (!got || pcm_bus.data !== 8'h72 || early !== 0) begin errors++; $display("FAIL inv_ok_dout got ok=%b %h early=%0d required ok=1 72 early=0", got, pcm_bus.data, early); end
        checks++; if (req_count - rc0 !== 2) begin errors++; $display("FAIL inv_ok_reqs got %0d required 2", req_count - rc0); end
        INVALIDATE = 1'b1;
        tick();
        INVALIDATE = 1'b0;
        checks++; if (pcm_bus.ok !== 1'b0) begin errors++; $display("FAIL inv_hit_ok got %b required 0", pcm_bus.ok); end
        wait_ok(30, got);
        checks++; if (!got || pcm_bus.data !== 8'h72 || req_count - rc0 !== 3) begin errors++; $display("FAIL inv_hit_refill got ok=%b %h reqs=%0d required ok=1 72 reqs=3", got, pcm_bus.data, req_count - rc0); end
    endtask

    task automatic test_reset_mid_req();
        bit got;
        int rc0;
        hold_check_en = 1'b0;
        pcm_bus.addr = 20'h00060;
        wait_sd_cs(got);
        tick();
        RESET96 = 1'b1;
        #1;
        checks++; if (sd_bus.cs !== 1'b0 || pcm_bus.ok !== 1'b0) begin errors++; $display("FAIL async_rst got cs=%b ok=%b required 0 0", sd_bus.cs, pcm_bus.ok); end
        pcm_bus.cs = 1'b0;
        repeat (2) tick();
        RESET96 = 1'b0;
        repeat (10) tick();
        hold_check_en = 1'b1;
        checks++; if (sd_bus.addr !== 19'h0) begin errors++; $display("FAIL rst_mid_sdaddr got %h required 0", sd_bus.addr); end
        rc0 = req_count;
        pcm_bus.cs   = 1'b1;
        pcm_bus.addr = 20'h00010;
        wait_ok(30, got);
        checks++; if (!got || pcm_bus.data !== 8'hEF || req_count - rc0 !== 1) begin errors++; $display("FAIL rst_refill got ok=%b %h reqs=%0d required ok=1 ef reqs=1", got, pcm_bus.data, req_count - rc0); end
    endtask

`ifdef PCM_FETCH_PREFETCH_EN
    task automatic test_prefetch();
        bit got;
        int rc0 = req_count;
        pcm_bus.cs   = 1'b1;
        pcm_bus.addr = 20'hFFFFE;
        wait_ok(30, got);
        checks++; if (!got || pcm_bus.data !== 8'hA5) begin errors++; $display("FAIL pf_demand got ok=%b %h required ok=1 a5", got, pcm_bus.data); end
        repeat (15) tick();
        checks++; if (last_req_addr !== 19'h00000 || req_count - rc0 !== 2) begin errors++; $display("FAIL pf_req got %h/%0d required 00000/2", last_req_addr, req_count - rc0); end
        pcm_bus.addr = 20'h00000;
        wait_ok(10, got);
        checks++; if (!got || pcm_bus.data !== 8'h5A || req_count - rc0 !== 2) begin errors++; $display("FAIL pf_hit got ok=%b %h reqs=%0d required ok=1 5a reqs=2", got, pcm_bus.data, req_count - rc0); end
    endtask
`endif

    initial begin
        pcm_bus.cs   = 1'b0;
        pcm_bus.addr = '0;
        test_reset();
`ifdef PCM_FETCH_PREFETCH_EN
        test_prefetch();
`else
        test_basic();
        test_conflict();
        test_addr_change();
        test_invalidate();
        test_inv_on_ok();
        test_reset_mid_req();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
